// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. One operation is
//   accepted from IDLE on start; multiplies run a shift-add loop and divides
//   a restoring loop, one bit per cycle, on operand magnitudes. Signs are
//   re-applied when the result is registered. Divide-by-zero and signed
//   overflow (most-negative / -1) skip the loop entirely.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   operation request, honoured only in IDLE
//   kill    synchronous abort, wins over start
//   funct3  instruction[14:12] selecting the operation (sampled with start)
//   op_a    rs1 value (sampled with start)
//   op_b    rs2 value (sampled with start)
//   busy    high while the FSM is not in IDLE
//   done    one-cycle pulse, result valid
//   result  operation result, held until the next completed operation
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Magnitude in XLEN+1 bits so the most-negative value does not overflow.
    // neg is only ever set when v's MSB is 1, so {neg, v} is a sign extension.
    function automatic logic [XLEN:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            neg);
        logic [XLEN:0] ext;
        ext = {neg, v};
        if (neg) begin
            magnitude = {(XLEN+1){1'b0}} - ext;
        end else begin
            magnitude = ext;
        end
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      funct3_r;
    logic            sa_r;
    logic            sb_r;
    logic            fast_r;
    logic [XLEN-1:0] fast_val_r;
    logic [XLEN:0]   dvs_r;        // multiplicand or divisor magnitude
    logic [2*XLEN:0] acc_r;        // {carry/remainder, product/quotient}
    logic            busy_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            a_signed_s;
    logic            b_signed_s;
    logic            sa_s;
    logic            sb_s;
    logic [XLEN:0]   mag_a_s;
    logic [XLEN:0]   mag_b_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_val_s;
    logic [2*XLEN:0] step_s;
    logic [XLEN-1:0] final_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic [XLEN-1:0] result_nxt_s;

    assign accept_s = (state_r == IDLE) && start && !kill;

    // Operand decode at issue: signedness, magnitudes and fast-path detection.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sa_s    = a_signed_s & op_a[XLEN-1];
        sb_s    = b_signed_s & op_b[XLEN-1];
        mag_a_s = magnitude(op_a, sa_s);
        mag_b_s = magnitude(op_b, sb_s);

        fast_s     = 1'b0;
        fast_val_s = ZERO;
        if (funct3[2] && (op_b == ZERO)) begin
            // funct3[1] selects remainder over quotient
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? op_a : ALL_ONES;
        end else if (funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == ALL_ONES)) begin
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? ZERO : op_a;
        end else begin
            fast_s     = 1'b0;
            fast_val_s = ZERO;
        end
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        logic [XLEN:0] addend;
        logic [XLEN:0] sum;
        logic [XLEN:0] trial;
        logic [XLEN:0] diff;
        logic          ge;
        addend = acc_r[0] ? dvs_r : {(XLEN+1){1'b0}};
        sum    = acc_r[2*XLEN:XLEN] + addend;
        trial  = acc_r[2*XLEN-1:XLEN-1];
        ge     = (trial >= dvs_r);
        diff   = trial - dvs_r;
        if (funct3_r[2]) begin
            step_s = {(ge ? diff : trial), acc_r[XLEN-2:0], ge};
        end else begin
            step_s = {1'b0, sum, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and field selection applied when the result is registered.
    always_comb begin
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = acc_r[2*XLEN-1:0];
        quo  = acc_r[XLEN-1:0];
        rem  = acc_r[2*XLEN-1:XLEN];
        if (sa_r ^ sb_r) begin
            prod = {(2*XLEN){1'b0}} - prod;
            quo  = ZERO - quo;
        end else begin
            prod = acc_r[2*XLEN-1:0];
            quo  = acc_r[XLEN-1:0];
        end
        if (sa_r) begin
            rem = ZERO - rem;
        end else begin
            rem = acc_r[2*XLEN-1:XLEN];
        end
        case (funct3_r)
            3'b000:                 final_s = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_s = quo;
            3'b110, 3'b111:         final_s = rem;
            default:                final_s = ZERO;
        endcase
        if (fast_r) begin
            final_s = fast_val_r;
        end else begin
            final_s = final_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; kill returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = fast_s ? FIN : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (kill) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        busy_nxt_s   = (state_nxt_s != IDLE);
        done_nxt_s   = 1'b0;
        result_nxt_s = result_r;
        if ((state_r == FIN) && !kill) begin
            done_nxt_s   = 1'b1;
            result_nxt_s = final_s;
        end else begin
            done_nxt_s   = 1'b0;
            result_nxt_s = result_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO;
        end else begin
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            result_r <= result_nxt_s;
        end
    end

    // Datapath: operand capture at issue, one iteration per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            funct3_r   <= 3'b000;
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
            fast_r     <= 1'b0;
            fast_val_r <= ZERO;
            dvs_r      <= {(XLEN+1){1'b0}};
            acc_r      <= {(2*XLEN+1){1'b0}};
        end else if (accept_s) begin
            cnt_r      <= CW'(XLEN-1);
            funct3_r   <= funct3;
            sa_r       <= sa_s;
            sb_r       <= sb_s;
            fast_r     <= fast_s;
            fast_val_r <= fast_val_s;
            // divide: divisor is op_b, dividend enters the quotient field
            // multiply: multiplicand is op_a, multiplier enters the low field
            if (funct3[2]) begin
                dvs_r <= mag_b_s;
                acc_r <= {{(XLEN+1){1'b0}}, mag_a_s[XLEN-1:0]};
            end else begin
                dvs_r <= mag_a_s;
                acc_r <= {{(XLEN+1){1'b0}}, mag_b_s[XLEN-1:0]};
            end
        end else if ((state_r == RUN) && !kill) begin
            acc_r <= step_s;
            if (cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors for muldiv_unit (XLEN=32). Issued operations push the
//   expected result and the expected done cycle into a scoreboard; a monitor
//   pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN   = 32;
    localparam int LAT_N  = XLEN + 1;   // edges from accept to done-visible
    localparam int LAT_F  = 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [XLEN-1:0] res;
        int              at;
        int              id;
    } exp_t;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    logic [XLEN-1:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: result=%h, no operation outstanding", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.res) begin
                    n_bad++;
                    $display("FAIL result[%0d]: got %h, expected %h", e.id, result, e.res);
                end
                n_vec++;
                if (cyc != e.at) begin
                    n_bad++;
                    $display("FAIL latency[%0d]: done at edge %0d, expected edge %0d", e.id, cyc, e.at);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive a start for one cycle, optionally scoreboard it.
    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] res, input int lat, input int id, input bit push);
        exp_t e;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        if (push) begin
            e.res = res;
            e.at  = cyc + 1 + lat;
            e.id  = id;
            sb.push_back(e);
            last_res = res;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: %0d operation(s) never completed", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
        chk("result_held", result, last_res);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
        vecs = '{
            '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_N},  // MUL 7*-3
            '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_N},  // MULH
            '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_N},  // MULHU
            '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_N},  // MULHSU
            '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_N},  // MUL -1*-1
            '{3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, LAT_N},  // MULHU
            '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_N},  // MULH 2^31 high
            '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_N},  // DIV -7/2
            '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_N},  // REM -7/2
            '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N},  // DIV 7/-2
            '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT_N},  // REM 7/-2
            '{3'b101, 32'd100,       32'd7,         32'd14,        LAT_N},  // DIVU
            '{3'b111, 32'd100,       32'd7,         32'd2,         LAT_N},  // REMU
            '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, LAT_N},  // DIVU no ovf path
            '{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, LAT_N},  // DIV most-neg/1
            '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_F},  // DIVU /0
            '{3'b110, 32'd5,         32'd0,         32'd5,         LAT_F},  // REM /0
            '{3'b111, 32'd5,         32'd0,         32'd5,         LAT_F},  // REMU /0
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_F},  // DIV overflow
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_F}   // REM overflow
        };

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors, one at a time
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i, 1'b1);
            chk("busy_after_start", {31'd0, busy}, 32'd1);
            drain();
        end

        // back-to-back: second start issued in the cycle done is visible
        issue(3'b101, 32'd100, 32'd7, 32'd14, LAT_N, 100, 1'b1);
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        issue(3'b111, 32'd100, 32'd7, 32'd2, LAT_N, 101, 1'b1);
        drain();

        // start during RUN with different operands is ignored
        issue(3'b000, 32'd6, 32'd9, 32'd54, LAT_N, 102, 1'b1);
        repeat (4) @(negedge clk);
        issue(3'b101, 32'd1000, 32'd3, 32'd0, 0, 103, 1'b0);
        drain();

        // kill at cycle 10 of a DIV
        issue(3'b100, 32'd1000, 32'd3, 32'd0, 0, 104, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_result", result, last_res);
        repeat (40) @(negedge clk);
        chk("kill_result_late", result, last_res);

        // kill together with start in IDLE: not accepted
        kill = 1'b1;
        issue(3'b000, 32'd2, 32'd2, 32'd0, 0, 105, 1'b0);
        kill = 1'b0;
        chk("kill_start_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-MUL
        issue(3'b000, 32'd3, 32'd5, 32'd0, 0, 106, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_idle_result", result, 32'd0);

        // recovery after reset
        issue(3'b000, 32'd3, 32'd4, 32'd12, LAT_N, 107, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
